yazmac_obegi: RTL and testbench



---
 rtl/yazmac_obegi_if.sv | 40 ++++
 rtl/yazmac_obegi.sv | 152 +++++++++++++++
 tb/tb_yazmac_obegi.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/yazmac_obegi_if.sv
// yazmac_obegi_if: groups the write-back, read, reservation and flush
// signals of the yazmac_obegi register file into one bundle.
// master = decode / write-back side, slave = register file.
interface yazmac_obegi_if #(
   parameter int unsigned VERI_BIT = 32
);
   // write-back port
   logic [4:0]          yaz_adres_i;
   logic [VERI_BIT-1:0] yaz_deger_i;
   logic                yaz_yazmac_i;
   // read request from decode
   logic [4:0]          oku_adres1_i;
   logic [4:0]          oku_adres2_i;
   logic                oku_gecerli_i;
   logic                durdur_i;
   // scoreboard control
   logic [4:0]          rezerve_adres_i;
   logic                rezerve_i;
   logic                temizle_i;
   // registered read results
   logic [VERI_BIT-1:0] oku_deger1_o;
   logic [VERI_BIT-1:0] oku_deger2_o;
   logic                mesgul1_o;
   logic                mesgul2_o;
   logic                oku_gecerli_o;

   modport master (
      output yaz_adres_i, yaz_deger_i, yaz_yazmac_i,
      output oku_adres1_i, oku_adres2_i, oku_gecerli_i, durdur_i,
      output rezerve_adres_i, rezerve_i, temizle_i,
      input  oku_deger1_o, oku_deger2_o, mesgul1_o, mesgul2_o, oku_gecerli_o
   );

   modport slave (
      input  yaz_adres_i, yaz_deger_i, yaz_yazmac_i,
      input  oku_adres1_i, oku_adres2_i, oku_gecerli_i, durdur_i,
      input  rezerve_adres_i, rezerve_i, temizle_i,
      output oku_deger1_o, oku_deger2_o, mesgul1_o, mesgul2_o, oku_gecerli_o
   );
endinterface

// File: rtl/yazmac_obegi.sv
// yazmac_obegi: integer register file with two registered read ports and a
// pending-write (busy) scoreboard for RAW hazard detection in decode.
// x0 is hardwired to zero and can never be marked busy.
// Optional macro YAZMAC_ATLATMA_EN: forward a same-edge write-back to a read
// port reading the same register (value and busy flag). Undefined by default,
// in which case reads see the pre-edge register value and busy bit.
module yazmac_obegi #(
   parameter int unsigned YAZMAC_SAYISI = 32,
   parameter int unsigned VERI_BIT      = 32
) (
   input logic           clk_i,
   input logic           rst_ni,
   yazmac_obegi_if.slave bus
);

   logic [VERI_BIT-1:0]      yazmac_q [YAZMAC_SAYISI];
   logic [YAZMAC_SAYISI-1:0] mesgul_q;
   logic [YAZMAC_SAYISI-1:0] mesgul_d;

   logic [VERI_BIT-1:0] oku_deger1_q, oku_deger1_d;
   logic [VERI_BIT-1:0] oku_deger2_q, oku_deger2_d;
   logic                mesgul1_q, mesgul1_d;
   logic                mesgul2_q, mesgul2_d;
   logic                oku_gecerli_q, oku_gecerli_d;

   logic                yaz_gecerli;
   logic                rezerve_gecerli;
   logic [VERI_BIT-1:0] ham_deger1, ham_deger2;
   logic                ham_mesgul1, ham_mesgul2;

   // qualify write-back and reservation strobes (x0 and out-of-range excluded)
   always_comb begin
      yaz_gecerli     = bus.yaz_yazmac_i && (bus.yaz_adres_i != '0) &&
                        (32'(bus.yaz_adres_i) < YAZMAC_SAYISI);
      rezerve_gecerli = bus.rezerve_i && !bus.durdur_i && !bus.temizle_i &&
                        (bus.rezerve_adres_i != '0) &&
                        (32'(bus.rezerve_adres_i) < YAZMAC_SAYISI);
   end

   // read multiplexers: pre-edge register value and busy bit, plus forwarding
   always_comb begin
      ham_deger1  = '0;
      ham_deger2  = '0;
      ham_mesgul1 = 1'b0;
      ham_mesgul2 = 1'b0;
      for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
         if (bus.oku_adres1_i == 5'(i)) begin
            ham_deger1  = yazmac_q[i];
            ham_mesgul1 = mesgul_q[i];
         end
         if (bus.oku_adres2_i == 5'(i)) begin
            ham_deger2  = yazmac_q[i];
            ham_mesgul2 = mesgul_q[i];
         end
      end
`ifdef YAZMAC_ATLATMA_EN
      // forwarded read: new value, busy only if the same edge re-reserves it
      if (yaz_gecerli && (bus.oku_adres1_i == bus.yaz_adres_i)) begin
         ham_deger1  = bus.yaz_deger_i;
         ham_mesgul1 = rezerve_gecerli && (bus.rezerve_adres_i == bus.oku_adres1_i);
      end
      if (yaz_gecerli && (bus.oku_adres2_i == bus.yaz_adres_i)) begin
         ham_deger2  = bus.yaz_deger_i;
         ham_mesgul2 = rezerve_gecerli && (bus.rezerve_adres_i == bus.oku_adres2_i);
      end
`endif
   end

   // scoreboard next state: flush clears all; otherwise clear on write-back,
   // then set on reservation so a newer owner wins a same-edge collision
   always_comb begin
      mesgul_d = mesgul_q;
      if (bus.temizle_i) begin
         mesgul_d = '0;
      end else begin
         for (int unsigned i = 1; i < YAZMAC_SAYISI; i++) begin
            if (yaz_gecerli && (bus.yaz_adres_i == 5'(i))) begin
               mesgul_d[i] = 1'b0;
            end
            if (rezerve_gecerli && (bus.rezerve_adres_i == 5'(i))) begin
               mesgul_d[i] = 1'b1;
            end
         end
      end
      mesgul_d[0] = 1'b0;
   end

   // output register next state: load when not stalled, flush invalidates
   always_comb begin
      oku_deger1_d  = oku_deger1_q;
      oku_deger2_d  = oku_deger2_q;
      mesgul1_d     = mesgul1_q;
      mesgul2_d     = mesgul2_q;
      oku_gecerli_d = oku_gecerli_q;
      if (!bus.durdur_i) begin
         oku_deger1_d  = ham_deger1;
         oku_deger2_d  = ham_deger2;
         mesgul1_d     = ham_mesgul1;
         mesgul2_d     = ham_mesgul2;
         oku_gecerli_d = bus.oku_gecerli_i;
      end
      if (bus.temizle_i) begin
         mesgul1_d     = 1'b0;
         mesgul2_d     = 1'b0;
         oku_gecerli_d = 1'b0;
      end
   end

   // register array: write-back port, x0 never written
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
            yazmac_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < YAZMAC_SAYISI; i++) begin
            if (yaz_gecerli && (bus.yaz_adres_i == 5'(i))) begin
               yazmac_q[i] <= bus.yaz_deger_i;
            end
         end
      end
   end

   // scoreboard and read output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mesgul_q      <= '0;
         oku_deger1_q  <= '0;
         oku_deger2_q  <= '0;
         mesgul1_q     <= 1'b0;
         mesgul2_q     <= 1'b0;
         oku_gecerli_q <= 1'b0;
      end else begin
         mesgul_q      <= mesgul_d;
         oku_deger1_q  <= oku_deger1_d;
         oku_deger2_q  <= oku_deger2_d;
         mesgul1_q     <= mesgul1_d;
         mesgul2_q     <= mesgul2_d;
         oku_gecerli_q <= oku_gecerli_d;
      end
   end

   // drive interface outputs from the output registers
   always_comb begin
      bus.oku_deger1_o  = oku_deger1_q;
      bus.oku_deger2_o  = oku_deger2_q;
      bus.mesgul1_o     = mesgul1_q;
      bus.mesgul2_o     = mesgul2_q;
      bus.oku_gecerli_o = oku_gecerli_q;
   end

endmodule

// File: tb/tb_yazmac_obegi.sv
// tb_yazmac_obegi: directed vector table, asynchronous reset sequence and a
// randomized run against a behavioural register-file/scoreboard model.
module tb_yazmac_obegi;

`ifdef YAZMAC_ATLATMA_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   yazmac_obegi_if #(.VERI_BIT(32)) bus ();

   yazmac_obegi #(.YAZMAC_SAYISI(32), .VERI_BIT(32)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        yaz;
      logic [4:0]  ya;
      logic [31:0] yd;
      logic [4:0]  a1, a2;
      logic        gec, dur, rez;
      logic [4:0]  ra;
      logic        tem;
      logic [31:0] e1, e2;
      logic        em1, em2, eg;
   } vec_t;

   function automatic vec_t row(logic yaz, logic [4:0] ya, logic [31:0] yd,
                                logic [4:0] a1, logic [4:0] a2, logic gec,
                                logic dur, logic rez, logic [4:0] ra, logic tem,
                                logic [31:0] e1, logic [31:0] e2,
                                logic em1, logic em2, logic eg);
      vec_t v;
      v.yaz = yaz; v.ya = ya; v.yd = yd; v.a1 = a1; v.a2 = a2; v.gec = gec;
      v.dur = dur; v.rez = rez; v.ra = ra; v.tem = tem;
      v.e1 = e1; v.e2 = e2; v.em1 = em1; v.em2 = em2; v.eg = eg;
      return v;
   endfunction

   task automatic drive(logic yaz, logic [4:0] ya, logic [31:0] yd, logic [4:0] a1,
                        logic [4:0] a2, logic gec, logic dur, logic rez,
                        logic [4:0] ra, logic tem);
      bus.yaz_yazmac_i    = yaz;
      bus.yaz_adres_i     = ya;
      bus.yaz_deger_i     = yd;
      bus.oku_adres1_i    = a1;
      bus.oku_adres2_i    = a2;
      bus.oku_gecerli_i   = gec;
      bus.durdur_i        = dur;
      bus.rezerve_i       = rez;
      bus.rezerve_adres_i = ra;
      bus.temizle_i       = tem;
   endtask

   task automatic check_outs(input string tag, logic [31:0] e1, logic [31:0] e2,
                             logic em1, logic em2, logic eg);
      check({tag, ".deger1"}, bus.oku_deger1_o, e1);
      check({tag, ".deger2"}, bus.oku_deger2_o, e2);
      check({tag, ".mesgul1"}, 32'(bus.mesgul1_o), 32'(em1));
      check({tag, ".mesgul2"}, 32'(bus.mesgul2_o), 32'(em2));
      check({tag, ".gecerli"}, 32'(bus.oku_gecerli_o), 32'(eg));
   endtask

   // behavioural model state
   logic [31:0] m_reg [32];
   bit          m_busy [32];
   logic [31:0] me1, me2;
   bit          mem1, mem2, meg;

   function automatic logic [31:0] m_val(logic [4:0] a, bit wr, logic [4:0] ya, logic [31:0] yd);
      if (a == 0) return 32'h0;
      if (BYP && wr && a == ya) return yd;
      return m_reg[a];
   endfunction

   function automatic bit m_bsy(logic [4:0] a, bit wr, logic [4:0] ya, bit rz, logic [4:0] ra);
      if (a == 0) return 1'b0;
      if (BYP && wr && a == ya) return rz && (ra == a);
      return m_busy[a];
   endfunction

   // evaluate one clock edge of the model using the currently driven inputs
   task automatic model_edge();
      bit wr, rz;
      wr = bus.yaz_yazmac_i && bus.yaz_adres_i != 0;
      rz = bus.rezerve_i && !bus.durdur_i && !bus.temizle_i && bus.rezerve_adres_i != 0;
      if (!bus.durdur_i) begin
         me1  = m_val(bus.oku_adres1_i, wr, bus.yaz_adres_i, bus.yaz_deger_i);
         me2  = m_val(bus.oku_adres2_i, wr, bus.yaz_adres_i, bus.yaz_deger_i);
         mem1 = m_bsy(bus.oku_adres1_i, wr, bus.yaz_adres_i, rz, bus.rezerve_adres_i);
         mem2 = m_bsy(bus.oku_adres2_i, wr, bus.yaz_adres_i, rz, bus.rezerve_adres_i);
         meg  = bus.oku_gecerli_i;
      end
      if (bus.temizle_i) begin
         mem1 = 1'b0; mem2 = 1'b0; meg = 1'b0;
      end
      if (wr) m_reg[bus.yaz_adres_i] = bus.yaz_deger_i;
      if (bus.temizle_i) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         if (wr) m_busy[bus.yaz_adres_i] = 1'b0;
         if (rz) m_busy[bus.rezerve_adres_i] = 1'b1;
      end
   endtask

   vec_t tab [$];

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      tab.push_back(row(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(row(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1));
      tab.push_back(row(1, 0, 32'h12345678, 0, 3, 1, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 9, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      tab.push_back(row(1, 9, 32'h11111111, 9, 9, 1, 0, 0, 0, 0,
                        BYP ? 32'h11111111 : 32'h0, BYP ? 32'h11111111 : 32'h0, !BYP, !BYP, 1));
      tab.push_back(row(0, 0, 0, 9, 9, 1, 0, 0, 0, 0, 32'h11111111, 32'h11111111, 0, 0, 1));
      tab.push_back(row(1, 9, 32'h22222222, 0, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 9, 9, 1, 0, 0, 0, 0, 32'h22222222, 32'h22222222, 1, 1, 1));
      tab.push_back(row(1, 9, 32'h33333333, 9, 0, 1, 0, 1, 9, 0,
                        BYP ? 32'h33333333 : 32'h22222222, 0, 1, 0, 1));
      tab.push_back(row(0, 0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 4, 6, 1, 0, 1, 6, 0, 0, 0, 1, 0, 1));
      tab.push_back(row(0, 0, 0, 4, 6, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(row(0, 0, 0, 4, 6, 1, 0, 1, 9, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(1, 5, 32'h00000055, 3, 9, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h33333333, 0, 1, 1));
      tab.push_back(row(1, 9, 32'h44444444, 5, 0, 0, 1, 0, 0, 0, 32'hA5A5A5A5, 32'h33333333, 0, 1, 1));
      tab.push_back(row(0, 0, 0, 9, 9, 0, 1, 1, 5, 0, 32'hA5A5A5A5, 32'h33333333, 0, 1, 1));
      tab.push_back(row(0, 0, 0, 5, 9, 1, 0, 0, 0, 0, 32'h00000055, 32'h44444444, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 1));
      tab.push_back(row(0, 0, 0, 5, 5, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0));
      tab.push_back(row(0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      // reset state while rst_n is held low
      #2;
      check_outs("reset", 0, 0, 0, 0, 0);
      #10 rst_n = 1'b1;

      // directed vector table
      foreach (tab[k]) begin
         drive(tab[k].yaz, tab[k].ya, tab[k].yd, tab[k].a1, tab[k].a2, tab[k].gec,
               tab[k].dur, tab[k].rez, tab[k].ra, tab[k].tem);
         @(posedge clk); #1;
         check_outs($sformatf("vec%0d", k), tab[k].e1, tab[k].e2, tab[k].em1, tab[k].em2, tab[k].eg);
      end

      // asynchronous reset mid-cycle after writing x5
      drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 0, 1, 6, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 5, 6, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_outs("pre_rst", 32'hDEADBEEF, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 5, 6, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_outs("post_rst", 0, 0, 0, 0, 1);

      // randomized run from the known post-reset state
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      me1 = 0; me2 = 0; mem1 = 0; mem2 = 0; meg = 1;
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 5);
         model_edge();
         @(posedge clk); #1;
         check_outs($sformatf("rnd%0d", n), me1, me2, mem1, mem2, meg);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
